// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared types and constants for the fetch PC redirect slice
package pc_redirect_unit_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;
  typedef enum logic {RUN, PEND} state_t;
  typedef enum logic [2:0] {SEL_HOLD, SEL_INC, SEL_TGT, SEL_PEND, SEL_TRAP} pc_sel_t;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: EX-side redirect request and IF-side fetch address bundle
interface pc_redirect_unit_if
  import pc_redirect_unit_pkg::*;
  #(parameter int CNT_W = 16);
  logic            next_pc_src;
  logic [XLEN-1:0] target_ex;
  logic            fetch_stall;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] pc_inc_if;
  logic            valid_if;
  logic            flush_id;
  logic            flush_ex;
  logic            misalign_err;
  logic [CNT_W-1:0] redir_cnt;
  modport master (output next_pc_src, target_ex, fetch_stall,
                  input pc_if, pc_inc_if, valid_if, flush_id, flush_ex, misalign_err, redir_cnt);
  modport slave (input next_pc_src, target_ex, fetch_stall,
                 output pc_if, pc_inc_if, valid_if, flush_id, flush_ex, misalign_err, redir_cnt);
endinterface

// File: rtl/pc_redirect_unit_fsm.sv
// pc_redirect_fsm: RUN/PEND control, pending target buffer, redirect counter and PC load select
module pc_redirect_fsm
  import pc_redirect_unit_pkg::*;
  #(parameter int CNT_W = 16)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_next_pc_src,
    input  logic             i_fetch_stall,
    input  logic             i_misalign,
    input  logic [XLEN-1:0]  i_target_ex,
    output pc_sel_t          o_sel,
    output logic             o_redirect,
    output logic             o_pend_st,
    output logic [XLEN-1:0]  o_pend,
    output logic [CNT_W-1:0] o_redir_cnt
  );
  state_t r_state, w_state_nxt;
  logic [XLEN-1:0] r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic w_accept;
  // Next state and PC select; requests in PEND are ignored since the pipeline behind was squashed
  always_comb begin
    w_state_nxt = r_state;
    o_sel = i_fetch_stall ? SEL_HOLD : SEL_INC;
    w_accept = 1'b0;
    o_redirect = rst_n && r_state == RUN && i_next_pc_src;
    if (r_state == PEND) begin
      o_sel = i_fetch_stall ? SEL_HOLD : SEL_PEND;
      w_state_nxt = i_fetch_stall ? PEND : RUN;
    end else if (o_redirect) begin
      if (i_misalign) begin
        o_sel = SEL_TRAP;
      end else begin
        w_accept = 1'b1;
        o_sel = i_fetch_stall ? SEL_HOLD : SEL_TGT;
        w_state_nxt = i_fetch_stall ? PEND : RUN;
      end
    end
  end
  // State, pending target and accepted-redirect counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pend <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && i_fetch_stall) r_pend <= i_target_ex;
      if (w_accept) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_pend_st = r_state == PEND;
  assign o_pend = r_pend;
  assign o_redir_cnt = r_cnt;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with EX redirect, stall buffering and misaligned-target trap
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
  #(
    parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF,
    parameter int CNT_W = 16
  )
  (
    input logic clk,
    input logic rst_n,
    pc_redirect_unit_if.slave bus
  );
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_pend;
  logic w_misalign, w_redirect, w_pend_st;
  pc_sel_t w_sel;
  logic [CNT_W-1:0] w_cnt;
  assign w_misalign = |bus.target_ex[1:0];
  pc_redirect_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk(clk),
    .rst_n(rst_n),
    .i_next_pc_src(bus.next_pc_src),
    .i_fetch_stall(bus.fetch_stall),
    .i_misalign(w_misalign),
    .i_target_ex(bus.target_ex),
    .o_sel(w_sel),
    .o_redirect(w_redirect),
    .o_pend_st(w_pend_st),
    .o_pend(w_pend),
    .o_redir_cnt(w_cnt)
  );
  // PC load mux driven by the FSM select
  always_comb begin
    w_pc_nxt = w_sel == SEL_INC  ? bus.pc_inc_if :
               w_sel == SEL_TGT  ? bus.target_ex :
               w_sel == SEL_PEND ? w_pend :
               w_sel == SEL_TRAP ? TRAP_VEC : r_pc;
  end
  // PC register; a trap loads even under stall so the memory sees the new address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_VEC;
    else r_pc <= w_pc_nxt;
  end
  assign bus.pc_if = r_pc;
  assign bus.pc_inc_if = r_pc + XLEN'(INSTR_BYTES);
  assign bus.valid_if = rst_n && !w_pend_st;
  assign bus.flush_id = w_redirect;
  assign bus.flush_ex = w_redirect;
  assign bus.misalign_err = w_redirect && w_misalign;
  assign bus.redir_cnt = w_cnt;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  pc_redirect_unit_if #(.CNT_W(4)) bus ();
  pc_redirect_unit #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic req, input logic [31:0] tgt, input logic stall);
    bus.next_pc_src = req;
    bus.target_ex = tgt;
    bus.fetch_stall = stall;
  endtask
  initial begin
    drive(1'b1, 32'h102, 1'b0);
    #1;
    check("rst_pc", bus.pc_if, 32'h0);
    check("rst_valid", 32'(bus.valid_if), 0);
    check("rst_flush_id", 32'(bus.flush_id), 0);
    check("rst_flush_ex", 32'(bus.flush_ex), 0);
    check("rst_mis", 32'(bus.misalign_err), 0);
    check("rst_cnt", 32'(bus.redir_cnt), 0);
    drive(1'b0, 32'h0, 1'b0);
    #11;
    rst_n = 1'b1;
    #1;
    check("rel_valid", 32'(bus.valid_if), 1);
    check("rel_pc", bus.pc_if, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("seq_pc", bus.pc_if, 32'(i * 4));
      check("seq_flush", 32'(bus.flush_id), 0);
    end
    drive(1'b1, 32'h80, 1'b0);
    #1;
    check("redir_flush_id", 32'(bus.flush_id), 1);
    check("redir_flush_ex", 32'(bus.flush_ex), 1);
    check("redir_mis", 32'(bus.misalign_err), 0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("redir_pc", bus.pc_if, 32'h80);
    check("redir_cnt", 32'(bus.redir_cnt), 1);
    drive(1'b1, 32'h40, 1'b0);
    tick();
    check("to40_pc", bus.pc_if, 32'h40);
    drive(1'b1, 32'h200, 1'b1);
    #1;
    check("stl_flush", 32'(bus.flush_id), 1);
    check("stl_valid", 32'(bus.valid_if), 1);
    tick();
    drive(1'b1, 32'h999, 1'b1);
    check("pend_cnt", 32'(bus.redir_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pend_pc", bus.pc_if, 32'h40);
      check("pend_valid", 32'(bus.valid_if), 0);
      check("pend_flush", 32'(bus.flush_ex), 0);
      check("pend_mis", 32'(bus.misalign_err), 0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("pend_last_valid", 32'(bus.valid_if), 0);
    tick();
    check("unpend_pc", bus.pc_if, 32'h200);
    check("unpend_valid", 32'(bus.valid_if), 1);
    check("unpend_cnt", 32'(bus.redir_cnt), 3);
    drive(1'b1, 32'h102, 1'b1);
    #1;
    check("mis_err", 32'(bus.misalign_err), 1);
    check("mis_flush", 32'(bus.flush_id), 1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("mis_pulse", 32'(bus.misalign_err), 0);
    check("trap_pc", bus.pc_if, 32'h100);
    check("trap_cnt", 32'(bus.redir_cnt), 3);
    check("trap_valid", 32'(bus.valid_if), 1);
    drive(1'b1, 32'h300, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    check("p300_valid", 32'(bus.valid_if), 0);
    check("p300_cnt", 32'(bus.redir_cnt), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", bus.pc_if, 32'h0);
    check("arst_valid", 32'(bus.valid_if), 0);
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arel_pc", bus.pc_if, 32'h0);
    check("arel_cnt", 32'(bus.redir_cnt), 0);
    tick();
    check("arel_pc4", bus.pc_if, 32'h4);
    tick();
    check("arel_pc8", bus.pc_if, 32'h8);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 8), 1'b0);
      tick();
      if (i == 15) check("cnt_wrap0", 32'(bus.redir_cnt), 0);
    end
    drive(1'b0, 32'h0, 1'b0);
    check("cnt_wrap1", 32'(bus.redir_cnt), 1);
    check("cnt_pc", bus.pc_if, 32'h1080);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("top_pc", bus.pc_if, 32'hFFFF_FFFC);
    check("top_inc", bus.pc_inc_if, 32'h0);
    tick();
    check("wrap_pc", bus.pc_if, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
